// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier: flag bit
// positions, FSM state encoding and the canonical quiet-NaN pattern.
package fp_pkg;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL    = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Sign 0, exponent all ones, only the mantissa MSB set; callers truncate to their width.
  function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify_p.sv
// Combinational classifier for one IEEE-754-style operand.
module fp_classify_p #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_x,
  output logic                 o_snan,
  output logic                 o_qnan,
  output logic                 o_inf,
  output logic                 o_zero,
  output logic                 o_subnormal,
  output logic                 o_normal,
  output logic                 o_sign
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_ones;
  logic             w_exp_zero;
  logic             w_man_zero;

  assign w_exp      = i_x[EXP_W+MAN_W-1:MAN_W];
  assign w_man      = i_x[MAN_W-1:0];
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;

  // The mantissa MSB distinguishes quiet from signalling NaNs.
  assign o_snan      = w_exp_ones & ~w_man_zero & ~w_man[MAN_W-1];
  assign o_qnan      = w_exp_ones & ~w_man_zero &  w_man[MAN_W-1];
  assign o_inf       = w_exp_ones &  w_man_zero;
  assign o_zero      = w_exp_zero &  w_man_zero;
  assign o_subnormal = w_exp_zero & ~w_man_zero;
  assign o_normal    = ~w_exp_zero & ~w_exp_ones;
  assign o_sign      = i_x[EXP_W+MAN_W];

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier: shift-add significand product, one
// multiplier bit per cycle, round-to-nearest-even, DAZ/FTZ, special cases.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int P    = MAN_W + 1;
  localparam int XW   = EXP_W + 2;
  localparam int CW   = $clog2(P + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic [XW-1:0] BIAS_X    = XW'(BIAS);
  localparam logic [XW-1:0] EXP_TOP   = XW'(2 ** EXP_W - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
  localparam logic [W-1:0]  QNAN      = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]  QUIET_BIT = W'(1) << (MAN_W - 1);

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_result;
  logic [3:0]       r_flags;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sign;
  logic [XW-1:0]    r_exp;
  logic [P-1:0]     r_mcand;
  logic [2*P-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_pend_res;
  logic [3:0]       r_pend_flags;

  logic w_snan_a, w_qnan_a, w_inf_a, w_zero_a, w_sub_a, w_norm_a, w_sign_a;
  logic w_snan_b, w_qnan_b, w_inf_b, w_zero_b, w_sub_b, w_norm_b, w_sign_b;

  fp_classify_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .i_x(r_a), .o_snan(w_snan_a), .o_qnan(w_qnan_a), .o_inf(w_inf_a), .o_zero(w_zero_a),
    .o_subnormal(w_sub_a), .o_normal(w_norm_a), .o_sign(w_sign_a)
  );

  fp_classify_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .i_x(r_b), .o_snan(w_snan_b), .o_qnan(w_qnan_b), .o_inf(w_inf_b), .o_zero(w_zero_b),
    .o_subnormal(w_sub_b), .o_normal(w_norm_b), .o_sign(w_sign_b)
  );

  logic          w_za;
  logic          w_zb;
  logic          w_sign;
  logic [XW-1:0] w_exp_sum;

  // Subnormal operands are treated as zero; exponents are two's complement in XW bits.
  assign w_za      = w_zero_a | w_sub_a;
  assign w_zb      = w_zero_b | w_sub_b;
  assign w_sign    = w_sign_a ^ w_sign_b;
  assign w_exp_sum = {2'b00, r_a[W-2:MAN_W]} + {2'b00, r_b[W-2:MAN_W]} - BIAS_X;

  logic         w_special;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flags;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_snan_a) begin
      w_spec_res = r_a | QUIET_BIT;
    end else if (w_snan_b) begin
      w_spec_res = r_b | QUIET_BIT;
    end else if (w_qnan_a) begin
      w_spec_res = r_a;
    end else if (w_qnan_b) begin
      w_spec_res = r_b;
    end else if ((w_inf_a && w_zb) || (w_inf_b && w_za)) begin
      w_spec_res = QNAN;
    end else if (w_inf_a || w_inf_b) begin
      w_spec_res           = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flags[FLAG_N] = w_sign;
    end else if (!(w_norm_a && w_norm_b)) begin
      w_spec_res           = {w_sign, {(W-1){1'b0}}};
      w_spec_flags[FLAG_N] = w_sign;
      w_spec_flags[FLAG_Z] = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  logic [P:0] w_sum;

  // Add the multiplicand into the upper half when the multiplier LSB (acc[0]) is set.
  assign w_sum = {1'b0, r_acc[2*P-1:P]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  logic [MAN_W-1:0] w_mant;
  logic             w_guard;
  logic             w_sticky;
  logic             w_rnd_up;
  logic [MAN_W:0]   w_mant_rnd;
  logic [XW-1:0]    w_exp_fin;
  logic [W-1:0]     w_rnd_res;
  logic [3:0]       w_rnd_flags;

  // After NORM the hidden one sits at bit 2P-2; guard is the first bit below the mantissa.
  assign w_mant     = r_acc[2*P-3:P-1];
  assign w_guard    = r_acc[P-2];
  assign w_sticky   = |r_acc[P-3:0];
  assign w_rnd_up   = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + (MAN_W+1)'(w_rnd_up);
  assign w_exp_fin  = r_exp + XW'(w_mant_rnd[MAN_W]);

  always_comb begin
    w_rnd_res           = {r_sign, w_exp_fin[EXP_W-1:0], w_mant_rnd[MAN_W-1:0]};
    w_rnd_flags         = '0;
    w_rnd_flags[FLAG_N] = r_sign;
    w_rnd_flags[FLAG_C] = w_guard | w_sticky;
    if (!w_exp_fin[XW-1] && (w_exp_fin >= EXP_TOP)) begin
      w_rnd_res           = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags[FLAG_C] = 1'b1;
      w_rnd_flags[FLAG_V] = 1'b1;
    end else if (w_exp_fin[XW-1] || (w_exp_fin == '0)) begin
      w_rnd_res           = {r_sign, {(W-1){1'b0}}};
      w_rnd_flags[FLAG_C] = 1'b1;
      w_rnd_flags[FLAG_Z] = 1'b1;
    end
  end

  // Control FSM with registered outputs; reset wins over any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= UNPACK;
            r_busy  <= 1'b1;
          end
        end
        UNPACK: r_state <= w_special ? DONE : MUL;
        MUL:    if (r_cnt == CNT_LAST) r_state <= NORM;
        NORM:   r_state <= ROUND;
        ROUND:  r_state <= DONE;
        DONE: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= r_pend_res;
          r_flags  <= r_pend_flags;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: datapath registers have no reset; each is written before the FSM reads it.
  always_ff @(posedge clk) begin
    unique case (r_state)
      IDLE: begin
        if (start) begin
          r_a <= a;
          r_b <= b;
        end
      end
      UNPACK: begin
        r_sign       <= w_sign;
        r_exp        <= w_exp_sum;
        r_mcand      <= {1'b1, r_a[MAN_W-1:0]};
        r_acc        <= {{P{1'b0}}, 1'b1, r_b[MAN_W-1:0]};
        r_cnt        <= '0;
        r_pend_res   <= w_spec_res;
        r_pend_flags <= w_spec_flags;
      end
      MUL: begin
        r_acc <= {w_sum, r_acc[P-1:1]};
        r_cnt <= r_cnt + CW'(1);
      end
      NORM: begin
        // The dropped LSB is folded into bit 0 so it still counts towards sticky.
        if (r_acc[2*P-1]) begin
          r_acc <= {1'b0, r_acc[2*P-1:2], |r_acc[1:0]};
          r_exp <= r_exp + XW'(1);
        end
      end
      ROUND: begin
        r_pend_res   <= w_rnd_res;
        r_pend_flags <= w_rnd_flags;
      end
      default: ;
    endcase
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; W = 1+EXP_W+MAN_W, P = MAN_W+1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have ports a, b  input  W  IEEE-754-style operands (sign, biased exponent, mantissa).
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port result  output  W  product, held from done until the next accepted start.
REQ-010 SHALL have port flags  output  4  [3]=N negative, [2]=Z zero, [1]=C inexact, [0]=V overflow; held with result.

Function
REQ-011 SHALL use FSM states IDLE, UNPACK, MUL, NORM, ROUND, DONE.
REQ-012 SHALL register a and b on the start cycle in IDLE; start is ignored in every other state.
REQ-013 SHALL move UNPACK->DONE for special cases and UNPACK->MUL otherwise.
REQ-014 SHALL multiply {1,man_a}x{1,man_b} by shift-add, one multiplier bit per cycle, exactly P cycles in MUL, into a 2P-bit product.
REQ-015 SHALL assert done P+4 cycles after the start sampling edge for the normal path and 2 cycles after it for special cases.
REQ-016 SHALL compute the exponent as ea+eb-bias in signed EXP_W+2-bit arithmetic, bias = 2^(EXP_W-1)-1.
REQ-017 NORM SHALL shift the product right by one and increment the exponent when the product MSB is set.
REQ-018 ROUND SHALL apply round-to-nearest-even using guard bit and OR-sticky of all lower bits, set C when guard or sticky is 1, and renormalise on mantissa carry-out (exponent+1).
REQ-019 SHALL emit signed infinity with V=1, C=1 when the final exponent is at least 2^EXP_W-1.
REQ-020 SHALL flush to signed zero with Z=1, C=1 when the final exponent is at most 0.
REQ-021 SHALL treat subnormal inputs as signed zero (DAZ).
REQ-022 Specials, in priority order: any signalling NaN (a before b) -> that NaN quieted (mantissa MSB set); any quiet NaN (a before b) -> that NaN; inf x zero -> canonical qNaN (sign 0, exponent all ones, mantissa MSB only); inf x other -> signed inf, V=0; zero x finite -> signed zero, Z=1.
REQ-023 Result sign SHALL be sign_a XOR sign_b except for the canonical NaN; N SHALL equal result[W-1]; NaN results SHALL set flags to 0000.

Reset
REQ-024 SHALL, on reset high at a clock edge, enter IDLE and force busy=0, done=0, result=0, flags=0000, regardless of state.
REQ-025 SHALL, after reset mid-operation, produce no done for the aborted operation and accept start on the first cycle after reset deasserts.

Structure
REQ-026 SHALL take flag bit indices, FSM state encodings and the canonical qNaN pattern from the shared package fp_pkg.
REQ-027 SHALL instantiate one sub-module, fp_classify_p (parametrised EXP_W/MAN_W), per operand, giving snan, qnan, inf, zero, subnormal, normal, and sign.
REQ-028 SHALL keep the multiplier, accumulator and counter in fp_mul_seq itself, with no combinational full-width multiply.

Verification
REQ-029 0x40400000 x 0x40200000 -> 0x40F00000, flags 0000, done 28 cycles after start.
REQ-030 0x3F800001 x 0x3F800001 -> 0x3F800002, flags 0010.
REQ-031 0x7F000000 x 0x40000000 -> 0x7F800000, flags 0011; 0x00800000 x 0x3F000000 -> 0x00000000, flags 0110.
REQ-032 0x7F800000 x 0x80000000 -> 0x7FC00000, flags 0000, done 2 cycles after start.
REQ-033 start pulsed again mid-MUL -> ignored, original result delivered once.
REQ-034 reset at cycle 10 of an operation -> busy 0, result 0, no done, and the next start completes normally.
REQ-035 EXP_W=5, MAN_W=10: 0x3C00 x 0xC000 -> 0xC000, flags 1000, done 15 cycles after start.
